oam_dma_controller: RTL

// - Sprite DMA engine for the NES: a CPU write to $4014 halts the 6502 via RDY and takes over the bus.
// - Copies TRANSFER_LENGTH bytes from CPU page $XX00..$XXFF to the PPU OAM data port $2004.
// - Sits between the cpu6502 core and the system bus mux, and arbitrates bus ownership between CPU and DMA.
// - Stalls the CPU timing sequence by holding RDY low, so the CPU TCU does not advance on halted read cycles.

---
 rtl/oam_dma_controller.sv | 108 ++++++++++
 1 files changed

// File: rtl/oam_dma_controller.sv
// Sprite DMA engine: a CPU write to the trigger address halts the CPU through RDY and copies one
// page of CPU memory to the PPU OAM data port, alternating get (read) and put (write) cycles.
module oam_dma_controller #(
  parameter logic [15:0] DMA_TRIGGER_ADDRESS = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDRESS    = 16'h2004,
  parameter int unsigned TRANSFER_LENGTH     = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_cpu_rdy,
  output logic        o_bus_request,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_data,
  output logic        o_busy
);

  typedef enum logic [2:0] {StIdle, StHalt, StAlign, StGet, StPut} state_e;

  localparam logic [7:0] LastIndex = 8'(TRANSFER_LENGTH - 1);

  state_e     state_q, state_d;
  logic       put_q, put_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      put_q   <= 1'b0;
      page_q  <= 8'h00;
      index_q <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      put_q   <= put_d;
      page_q  <= page_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  // put_q is a free-running get/put parity that the transfer aligns itself to.
  always_comb begin
    state_d = state_q;
    put_d   = ~put_q;
    page_d  = page_q;
    index_d = index_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (!i_cpu_rw && (i_cpu_address == DMA_TRIGGER_ADDRESS)) begin
          page_d  = i_cpu_data;
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (i_cpu_rw) begin
          state_d = put_q ? StGet : StAlign;
        end
      end
      StAlign: begin
        state_d = StGet;
      end
      StGet: begin
        data_d  = i_bus_data;
        state_d = StPut;
      end
      StPut: begin
        if (index_q == LastIndex) begin
          index_d = 8'h00;
          state_d = StIdle;
        end else begin
          index_d = index_q + 8'h01;
          state_d = StGet;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_cpu_rdy     = (state_q == StIdle);
    o_busy        = ~o_cpu_rdy;
    o_bus_request = 1'b0;
    o_address     = 16'h0000;
    o_rw          = 1'b1;
    o_data        = data_q;
    case (state_q)
      StGet: begin
        o_bus_request = 1'b1;
        o_address     = {page_q, index_q};
      end
      StPut: begin
        o_bus_request = 1'b1;
        o_address     = OAM_DATA_ADDRESS;
        o_rw          = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
